// File: rtl/instr_encoder_loader_pkg.sv
// Shared encodings for the instruction encoder/loader and its decoder counterpart:
// format-class codes, opcode constants, the NOP word and the loader FSM states.
package instr_encoder_loader_pkg;

  localparam logic [2:0] KIND_I = 3'b000;
  localparam logic [2:0] KIND_S = 3'b001;
  localparam logic [2:0] KIND_B = 3'b010;
  localparam logic [2:0] KIND_U = 3'b011;
  localparam logic [2:0] KIND_J = 3'b100;
  localparam logic [2:0] KIND_R = 3'b111;

  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_REG  = 7'b0110011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRX = 3'b101;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/instr_encoder_loader_pack.sv
// Combinational field-to-word packer for RV32I formats; illegal kinds yield a NOP.
module instr_encoder_loader_pack
  import instr_encoder_loader_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = NOP_WORD;
    illegal = 1'b0;
    case (kind)
      KIND_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
      KIND_I: begin
        // Immediate shifts carry funct7 in the upper bits and a 5-bit shamt
        if (opcode == OP_IMM && (funct3 == F3_SLL || funct3 == F3_SRX))
          word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
        else
          word = {imm[11:0], rs1, funct3, rd, opcode};
      end
      KIND_S: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      KIND_B: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      KIND_U: word = {imm[31:12], rd, opcode};
      KIND_J: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Accepts decoded instruction beats, encodes them and writes them sequentially into
// instruction memory; holds the core until the program is fully loaded.
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err_full,
  output logic              err_kind,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

  state_t      state, state_nxt;
  logic        last_seen;
  logic        accept;
  logic        start_load;
  logic [31:0] packed_word;
  logic        kind_illegal;

  instr_encoder_loader_pack u_pack (
    .kind    (in_kind),
    .opcode  (in_opcode),
    .rd      (in_rd),
    .rs1     (in_rs1),
    .rs2     (in_rs2),
    .funct3  (in_funct3),
    .funct7  (in_funct7),
    .imm     (in_imm),
    .word    (packed_word),
    .illegal (kind_illegal)
  );

  assign in_ready   = (state == ST_LOAD) && !last_seen && (word_count < DEPTH_CNT);
  assign accept     = in_valid && in_ready;
  assign start_load = start && (state != ST_LOAD);
  assign done       = (state == ST_DONE);
  assign cpu_hold   = (state != ST_DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_LOAD;
      // Leave LOAD one cycle after the final write is presented on the port
      ST_LOAD: if (last_seen || word_count == DEPTH_CNT) state_nxt = ST_DONE;
      ST_DONE: if (start) state_nxt = ST_LOAD;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      last_seen  <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      err_full   <= 1'b0;
      err_kind   <= 1'b0;
      word_count <= '0;
    end else begin
      state   <= state_nxt;
      imem_we <= 1'b0;
      if (start_load) begin
        last_seen  <= 1'b0;
        imem_addr  <= '0;
        err_full   <= 1'b0;
        err_kind   <= 1'b0;
        word_count <= '0;
      end else if (accept) begin
        imem_we    <= 1'b1;
        imem_addr  <= word_count[ADDR_W-1:0];
        imem_wdata <= packed_word;
        word_count <= word_count + 1'b1;
        if (in_last)      last_seen <= 1'b1;
        if (kind_illegal) err_kind  <= 1'b1;
        if (!in_last && word_count == DEPTH_CNT - 1'b1) err_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: the driver queues expected writes,
// an independent monitor pops and compares each imem write with its cycle.
module tb_instr_encoder_loader;
  import instr_encoder_loader_pkg::*;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [2:0]        in_kind = '0;
  logic [6:0]        in_opcode = '0;
  logic [4:0]        in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]        in_funct3 = '0;
  logic [6:0]        in_funct7 = '0;
  logic [31:0]       in_imm = '0;
  logic              in_last = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold, done, err_full, err_kind;
  logic [ADDR_W:0]   word_count;

  instr_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .in_last(in_last), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .done(done), .err_full(err_full), .err_kind(err_kind),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    int                cyc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   exp_addr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every write must match the head of the expected queue, in the right cycle
  always @(negedge clk) begin
    if (reset && imem_we) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: addr=%0d data=0x%08h, expected no write", imem_addr, imem_wdata);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (imem_addr !== e.addr || imem_wdata !== e.data) begin
          bad++;
          $display("FAIL write: got addr=%0d data=0x%08h expected addr=%0d data=0x%08h",
                   imem_addr, imem_wdata, e.addr, e.data);
        end
        total++;
        if (cyc != e.cyc) begin
          bad++;
          $display("FAIL write_cycle: got cycle %0d expected cycle %0d", cyc, e.cyc);
        end
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_addr = 0;
  endtask

  // Called at a negedge; presents one beat and returns at the negedge after it is taken
  task automatic send(input logic [2:0] kind, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm, input logic last,
                      input logic [31:0] exp_word);
    int tries = 0;
    exp_t e;
    in_kind = kind; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_last = last;
    in_valid = 1'b1;
    while (!in_ready && tries < 50) begin
      @(negedge clk);
      tries++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL send_timeout: in_ready=0 after %0d cycles, required 1", tries);
    end else begin
      e.addr = exp_addr[ADDR_W-1:0];
      e.data = exp_word;
      e.cyc  = cyc + 1;
      q.push_back(e);
      exp_addr++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drained", 32'(q.size()), 32'd0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_imem_we", {31'd0, imem_we}, 32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'd0);
    chk("rst_imem_wdata", imem_wdata, 32'd0);
    chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err_full", {31'd0, err_full}, 32'd0);
    chk("rst_err_kind", {31'd0, err_kind}, 32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk_reset_vals();
    reset = 1'b1;
    @(negedge clk);
    chk("idle_ready", {31'd0, in_ready}, 32'd0);

    // Program 1: add, addi, sw, beq, jal, lui with last
    pulse_start();
    chk("load_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    send(KIND_R, OP_REG, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0, 32'h002081B3);
    send(KIND_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0, 32'h00500093);
    send(KIND_S, OP_STORE, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8, 1'b0, 32'h0020A423);
    send(KIND_B, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC, 1'b0, 32'hFE208EE3);
    send(KIND_J, OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 1'b0, 32'h008000EF);
    // slli x4,x1,3: funct7 in upper bits, shamt from imm[4:0]
    send(KIND_I, OP_IMM, 5'd4, 5'd1, 5'd0, F3_SLL, 7'd0, 32'd3, 1'b0, 32'h00309213);
    send(KIND_U, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b1, 32'h123452B7);
    chk("last_ready_drop", {31'd0, in_ready}, 32'd0);
    wait_drain();
    @(negedge clk);
    chk("done_after_last", {31'd0, done}, 32'd1);
    chk("hold_released", {31'd0, cpu_hold}, 32'd0);
    chk("count_after_last", 32'(word_count), 32'd7);
    // Beats offered in DONE must not be written
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;

    // Program 2: illegal kind writes NOP and flags, next beat encodes normally
    pulse_start();
    chk("restart_done_clr", {31'd0, done}, 32'd0);
    chk("restart_count_clr", 32'(word_count), 32'd0);
    send(3'b101, OP_REG, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0, NOP_WORD);
    chk("err_kind_set", {31'd0, err_kind}, 32'd1);
    send(KIND_R, OP_REG, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1, 32'h002081B3);
    wait_drain();
    @(negedge clk);
    chk("err_kind_sticky", {31'd0, err_kind}, 32'd1);
    chk("err_full_clear", {31'd0, err_full}, 32'd0);

    // Program 3: overrun DEPTH with no last, streamed one beat per cycle
    pulse_start();
    chk("restart_err_kind_clr", {31'd0, err_kind}, 32'd0);
    for (int i = 0; i < DEPTH + 5; i++) begin
      exp_t e;
      in_kind = KIND_I; in_opcode = OP_IMM; in_rd = 5'(i); in_rs1 = 5'd0;
      in_funct3 = 3'd0; in_imm = 32'(i); in_last = 1'b0; in_valid = 1'b1;
      chk($sformatf("full_ready_%0d", i), {31'd0, in_ready}, (i < DEPTH) ? 32'd1 : 32'd0);
      if (i < DEPTH) begin
        e.addr = exp_addr[ADDR_W-1:0];
        e.data = (32'(i) << 20) | (32'(i % 32) << 7) | 32'h13;
        e.cyc  = cyc + 1;
        q.push_back(e);
        exp_addr++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_drain();
    chk("full_err_full", {31'd0, err_full}, 32'd1);
    chk("full_done", {31'd0, done}, 32'd1);
    chk("full_count", 32'(word_count), 32'd64);
    chk("full_ready_after", {31'd0, in_ready}, 32'd0);

    // Program 4: reset mid-load, then reload from address 0
    pulse_start();
    send(KIND_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0, 32'h00500093);
    send(KIND_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0, 32'h00500093);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_reset_vals();
    chk("reset_queue_empty", 32'(q.size()), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    pulse_start();
    send(KIND_U, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b1, 32'h123452B7);
    wait_drain();
    @(negedge clk);
    chk("reload_done", {31'd0, done}, 32'd1);
    chk("reload_count", 32'(word_count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
